// File: rtl/ahb_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_pkg
// Purpose  : Shared encodings for the AHB-lite SRAM front end: HTRANS,
//            HSIZE and HRESP codes plus the controller state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // DATA: zero-wait data phase; ERR1/ERR2: two-cycle ERROR response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage : ahb_sram_pkg
`default_nettype wire

// File: rtl/ahb_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_ctrl_if
// Purpose  : AHB-lite slave-side bus bundle (32-bit address and data).
// Ports    : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY  (to slave)
//            HREADYOUT, HRESP, HRDATA                           (from slave)
//            modports: master, slave
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_sram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface : ahb_sram_ctrl_if
`default_nettype wire

// File: rtl/ahb_sram_ctrl_lane_mask.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_lane_mask
// Purpose  : Converts a data-phase transfer size and byte offset into a
//            little-endian byte-lane mask (lane k = bits 8k+7:8k).
// Ports    : size [2:0]  transfer size (HSIZE encoding)
//            off  [1:0]  byte offset within the word
//            mask [31:0] bit mask, each lane expanded to 8 bits
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_lane_mask
    import ahb_sram_pkg::*;
(
    input  wire  [2:0]  size,
    input  wire  [1:0]  off,
    output logic [31:0] mask
);

    logic [3:0] w_lanes;

    always_comb begin
        w_lanes = 4'hF;
        case (size)
            HSIZE_BYTE: w_lanes = 4'b0001 << off;
            HSIZE_HALF: w_lanes = off[1] ? 4'b1100 : 4'b0011;
            default:    w_lanes = 4'hF;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{w_lanes[k]}};
        end
    end

endmodule : ahb_sram_lane_mask
`default_nettype wire

// File: rtl/ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_ctrl
// Purpose  : AHB-lite slave front end for a single-port SRAM with a
//            registered address. The address phase drives the SRAM address,
//            the data phase writes (read-modify-merge) or returns sram_q.
//            Word accesses have zero wait states; illegal transfers get the
//            two-cycle ERROR response.
// Ports    : clk, rst          clock, asynchronous active-high reset
//            ahb (slave)       AHB-lite bus bundle
//            sram_addr/data/wren  SRAM address, write data, write enable
//            sram_q            SRAM read data (from its registered address)
// Options  : AHB_SRAM_BYTE_WRITE_EN - when defined, byte and halfword
//            writes are merged into the word; otherwise they are illegal.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire                 clk,
    input  wire                 rst,
    ahb_sram_ctrl_if.slave      ahb,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_data,
    output logic                sram_wren,
    input  wire  [DATA_W-1:0]   sram_q
);

`ifdef AHB_SRAM_BYTE_WRITE_EN
    localparam bit C_BYTE_WRITE_EN = 1'b1;
`else
    localparam bit C_BYTE_WRITE_EN = 1'b0;
`endif

    // Address bits above the window select the slave
    localparam logic [31:0] C_WIN_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_size_bad;
    logic w_misaligned;
    logic w_out_window;
    logic w_subword_write;
    logic w_illegal;

    assign w_accept = ahb.HSEL & ahb.HREADY &
                      ((ahb.HTRANS == HTRANS_NONSEQ) | (ahb.HTRANS == HTRANS_SEQ));

    assign w_size_bad   = (ahb.HSIZE > HSIZE_WORD);
    assign w_misaligned = ((ahb.HSIZE == HSIZE_HALF) & ahb.HADDR[0]) |
                          ((ahb.HSIZE == HSIZE_WORD) & (ahb.HADDR[1:0] != 2'b00));
    assign w_out_window = ((ahb.HADDR & C_WIN_MASK) != (BASE_ADDR & C_WIN_MASK));

    // Without byte-write support, partial writes cannot be merged
    assign w_subword_write = !C_BYTE_WRITE_EN & ahb.HWRITE & (ahb.HSIZE != HSIZE_WORD);

    assign w_illegal = w_size_bad | w_misaligned | w_out_window | w_subword_write;

    // ------------------------------------------------------------------
    // Data-phase registers
    // ------------------------------------------------------------------
    logic              r_dp_valid;
    logic              r_dp_write;
    logic [2:0]        r_dp_size;
    logic [1:0]        r_dp_off;
    logic              r_dp_err;
    logic [ADDR_W-1:0] r_dp_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_size  <= 3'd0;
            r_dp_off   <= 2'd0;
            r_dp_err   <= 1'b0;
            r_dp_addr  <= '0;
        end else if (w_accept) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= ahb.HWRITE;
            r_dp_size  <= ahb.HSIZE;
            r_dp_off   <= ahb.HADDR[1:0];
            r_dp_err   <= w_illegal;
            r_dp_addr  <= ahb.HADDR[ADDR_W+1:2];
        end else if (ahb.HREADY) begin
            r_dp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM. IDLE, DATA and ERR2 all advance on the transfer seen
    // while HREADY is high; a stalled bus holds the current data phase.
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_accept_state;
    logic   r_hreadyout;
    logic   r_hresp;

    always_comb begin
        w_accept_state = ST_IDLE;
        if (w_accept) begin
            w_accept_state = w_illegal ? ST_ERR1 : ST_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (ahb.HREADY) begin
                        r_state     <= w_accept_state;
                        r_hreadyout <= (w_accept_state != ST_ERR1);
                        r_hresp     <= (w_accept_state == ST_ERR1) ? HRESP_ERROR : HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign ahb.HREADYOUT = r_hreadyout;
    assign ahb.HRESP     = r_hresp;
    assign ahb.HRDATA    = (r_state == ST_DATA) ? sram_q : '0;

    // ------------------------------------------------------------------
    // SRAM side. The SRAM registers sram_addr every cycle, so during a
    // stall the data-phase address is re-presented to keep it stable.
    // ------------------------------------------------------------------
    logic [31:0] w_lane_mask;
    logic [31:0] w_mask;

    ahb_sram_lane_mask u_lane_mask (
        .size (r_dp_size),
        .off  (r_dp_off),
        .mask (w_lane_mask)
    );

    assign w_mask = w_lane_mask | {32{!C_BYTE_WRITE_EN}};

    assign sram_addr = ahb.HREADY ? ahb.HADDR[ADDR_W+1:2] : r_dp_addr;
    assign sram_wren = (r_state == ST_DATA) & r_dp_valid & r_dp_write & !r_dp_err;
    assign sram_data = (ahb.HWDATA & w_mask) | (sram_q & ~w_mask);

endmodule : ahb_sram_ctrl
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_ctrl
// Purpose  : Self-checking bench for ahb_sram_ctrl with an SRAM model
//            (registered address, combinational q) and a word-array
//            reference memory updated by byte-lane rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_ctrl;

`ifdef AHB_SRAM_BYTE_WRITE_EN
    localparam bit BW = 1'b1;
`else
    localparam bit BW = 1'b0;
`endif
    localparam logic [31:0] TB_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [9:0]  sram_addr;
    logic [31:0] sram_data;
    logic        sram_wren;
    logic [31:0] sram_q;

    always #5 clk = ~clk;

    ahb_sram_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT & ~stall;

    ahb_sram_ctrl #(
        .ADDR_W    (10),
        .DATA_W    (32),
        .BASE_ADDR (TB_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ahb       (bus.slave),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_wren (sram_wren),
        .sram_q    (sram_q)
    );

    // SRAM macro model
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [9:0]  sram_ra = '0;
    always @(posedge clk) begin
        if (sram_wren) mem[sram_ra] <= sram_data;
        sram_ra <= sram_addr;
    end
    assign sram_q = mem[sram_ra];

    // Reference memory and pending data-phase record
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    bit          p_valid, p_write, p_err, p_use_tab;
    int          p_word;
    logic [1:0]  p_off;
    logic [2:0]  p_size;
    logic [31:0] p_wdata, p_tab_rd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit illegal(input bit wr, input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        if ((a - TB_BASE) >= 32'h1000) return 1'b1;
        if (!BW && wr && s != 3'd2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input int w, input logic [1:0] off, input logic [2:0] s,
                               input logic [31:0] d);
        int nb;
        nb = 1 << s;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(off) && b < int'(off) + nb) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] exp_read();
        return p_use_tab ? p_tab_rd : ref_mem[p_word];
    endfunction

    // One bus cycle (two if the pending transfer errors): present an address
    // phase, check the previous transfer's data phase, advance the model.
    task automatic step(input bit tv, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input bit use_tab, input bit tab_err, input logic [31:0] tab_rd);
        bus.HSEL   = 1'b1;
        bus.HTRANS = tv ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
        if (!tv && $urandom_range(0, 2) == 0) begin
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b10;
        end
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HWDATA = p_wdata;
        if (p_valid && p_err) begin
            @(negedge clk);
            chk("err1_hreadyout", 32'(bus.HREADYOUT), 32'd0);
            chk("err1_hresp",     32'(bus.HRESP),     32'd1);
            chk("err1_wren",      32'(sram_wren),     32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("err2_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            chk("err2_hresp",     32'(bus.HRESP),     32'd1);
            chk("err2_wren",      32'(sram_wren),     32'd0);
            chk("err2_hrdata",    bus.HRDATA,         32'd0);
        end else begin
            @(negedge clk);
            chk("okay_hreadyout", 32'(bus.HREADYOUT), 32'd1);
            chk("okay_hresp",     32'(bus.HRESP),     32'd0);
            chk("wren",           32'(sram_wren),     32'(p_valid && p_write));
            if (p_valid && !p_write) chk("rdata", bus.HRDATA, exp_read());
            else if (!p_valid)       chk("idle_hrdata", bus.HRDATA, 32'd0);
        end
        chk("sram_addr", 32'(sram_addr), 32'(addr[11:2]));
        @(posedge clk);
        if (p_valid && !p_err && p_write) model_write(p_word, p_off, p_size, p_wdata);
        p_valid   = tv;
        p_write   = wr;
        p_word    = int'(addr[11:2]);
        p_off     = addr[1:0];
        p_size    = size;
        p_wdata   = wdata;
        p_use_tab = use_tab;
        p_tab_rd  = tab_rd;
        p_err     = use_tab ? tab_err : illegal(wr, addr, size);
        #1;
    endtask

    // Hold HREADY low for n cycles during the pending (legal) data phase
    task automatic stall_cycles(input int n);
        stall      = 1'b1;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 32'h0000_0FFC;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd2;
        bus.HWDATA = p_wdata;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("stall_sram_addr", 32'(sram_addr), 32'(p_word));
            chk("stall_hresp",     32'(bus.HRESP), 32'd0);
            chk("stall_wren",      32'(sram_wren), 32'(p_write));
            if (!p_write) chk("stall_rdata", bus.HRDATA, exp_read());
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tab[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd2; bus.HWDATA = '0;
        p_valid = 0; p_write = 0; p_err = 0; p_use_tab = 0; p_word = 0;
        p_off = '0; p_size = '0; p_wdata = '0; p_tab_rd = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("reset_hresp",     32'(bus.HRESP),     32'd0);
        chk("reset_hrdata",    bus.HRDATA,         32'd0);
        chk("reset_wren",      32'(sram_wren),     32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        tab.push_back('{1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0});
        tab.push_back('{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF});
        tab.push_back('{1'b1, 32'h020, 3'd2, 32'h11223344, 1'b0, 32'h0});
        tab.push_back('{1'b1, 32'h022, 3'd0, 32'h00AA0000, !BW,  32'h0});
        tab.push_back('{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, BW ? 32'h11AA3344 : 32'h11223344});
        tab.push_back('{1'b1, 32'h023, 3'd1, 32'h55665566, 1'b1, 32'h0});
        tab.push_back('{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, BW ? 32'h11AA3344 : 32'h11223344});
        tab.push_back('{1'b0, 32'h1000, 3'd2, 32'h0,       1'b1, 32'h0});
        tab.push_back('{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF});
        tab.push_back('{1'b0, 32'h030, 3'd3, 32'h0,        1'b1, 32'h0});
        tab.push_back('{1'b0, 32'h012, 3'd1, 32'h0,        1'b0, 32'hDEADBEEF});
        tab.push_back('{1'b0, 32'h011, 3'd0, 32'h0,        1'b0, 32'hDEADBEEF});
        tab.push_back('{1'b1, 32'h014, 3'd1, 32'hCAFEBABE, !BW,  32'h0});
        tab.push_back('{1'b0, 32'h014, 3'd2, 32'h0,        1'b0, BW ? 32'h0000BABE : 32'h0});
        foreach (tab[i]) begin
            step(1'b1, tab[i].wr, tab[i].addr, tab[i].size, tab[i].wdata,
                 1'b1, tab[i].exp_err, tab[i].exp_rd);
        end
        step(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);

        // Read, then master stall for three cycles before releasing
        step(1'b1, 1'b0, 32'h010, 3'd2, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        stall_cycles(3);
        step(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset during a write data phase: the write must not land
        step(1'b1, 1'b1, 32'h040, 3'd2, 32'h5555AAAA, 1'b1, 1'b0, 32'h0);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = p_wdata;
        #2;
        chk("pre_rst_wren", 32'(sram_wren), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("mid_rst_hresp",     32'(bus.HRESP),     32'd0);
        chk("mid_rst_wren",      32'(sram_wren),     32'd0);
        @(negedge clk) rst = 1'b0;
        p_valid = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h040, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [2:0]  s;
            int          r;
            bit          tv, wr;
            if (p_valid && !p_err && $urandom_range(0, 9) == 0)
                stall_cycles(int'($urandom_range(1, 3)));
            r  = int'($urandom_range(0, 9));
            s  = (r == 0) ? 3'd3 : (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : 3'd2;
            a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (s == 3'd0 || $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) a = a + (32'h1000 << $urandom_range(0, 19));
            tv = ($urandom_range(0, 4) != 0);
            wr = 1'($urandom_range(0, 1));
            step(tv, wr, a, s, $urandom(), 1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ahb_sram_ctrl
`default_nettype wire
